multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Moore FSM sequencer for the multicycle RV32 core: the driving end of the ALU interface. It decodes
//  the IR contents and issues ALUControl, operand selects and register/memory/PC strobes, one state
//  per cycle. It consumes the ALU zero flag for branches. Sits between the IR/datapath and the ALU.
//  Supports lw, sw, R-type, I-type ALU, beq/bne and jal.
// PARAMETERS
//  SUPPORT_BNE  1  1: funct3=001 branch is bne; 0: funct3=001 branch is illegal
//  STATE_W      4  width of state register / state_o
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  instr      in   32  registered IR contents (op=[6:0], funct3=[14:12], funct7b5=[30])
//  zero       in   1   ALU Result==0 flag
//  mem_ready  in   1   memory handshake; access completes in a cycle where it is high
//  ALUControl out  3   000 add,001 sub,010 and,011 or,100 xor,101 slt,110 sll,111 srl
//  ALUSrcA    out  2   00 PC, 01 OldPC, 10 rs1
//  ALUSrcB    out  2   00 rs2, 01 imm, 10 const 4
//  ResultSrc  out  2   00 ALUOut, 01 mem data, 10 ALU result
//  ImmSrc     out  2   00 I, 01 S, 10 B, 11 J (combinational from opcode)
//  AdrSrc     out  1   0 PC, 1 ALUOut
//  IRWrite, PCWrite, MemWrite, RegWrite  out 1 each  strobes
//  illegal    out  1   high while in ILLEGAL
//  state_o    out  STATE_W  current state code (debug)
// BEHAVIOUR
//  Reset: state=FETCH, illegal=0. While rst=1, all strobes=0. Other outputs follow the FETCH decode.
//  Strobes are gated Moore outputs. The PCWrite branch term is the only zero-dependent output.
//  FETCH   : AdrSrc=0, A=00, B=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready.
//            Stay until mem_ready, then ->DECODE.
//  DECODE  : A=01, B=01, add (branch/jal target into ALUOut). Next state by opcode:
//            0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//            1101111->JAL, other->ILLEGAL.
//  MEMADR  : A=10, B=01, add. ->MEMREAD (lw) or ->MEMWRITE (sw).
//  MEMREAD : AdrSrc=1, ResultSrc=00. Wait for mem_ready, then ->MEMWB.
//  MEMWB   : ResultSrc=01, RegWrite=1. ->FETCH.
//  MEMWRITE: AdrSrc=1, MemWrite=1 held until the mem_ready cycle. ->FETCH on mem_ready.
//  EXECR   : A=10, B=00, ALUControl=aludec. ->ALUWB.  EXECI: A=10, B=01, aludec. ->ALUWB.
//  ALUWB   : ResultSrc=00, RegWrite=1. ->FETCH.
//  BRANCH  : A=10, B=00, sub, ResultSrc=00. PCWrite=zero (beq) or ~zero (bne). ->FETCH.
//  JAL     : A=01, B=10, add, ResultSrc=00, PCWrite=1. ->ALUWB (rd<=PC+4).
//  ILLEGAL : all strobes 0, illegal=1. Absorbing state; left only via rst.
//  aludec (funct3):
//    000 -> add; sub only when R-type and funct7b5=1 (addi never subtracts).
//    111 -> and.  110 -> or.  100 -> xor.  010/011 -> slt.  001 -> sll.
//    101 -> srl when funct7b5=0; ->ILLEGAL (decided in DECODE) when funct7b5=1 (no sra).
//    Branch funct3 other than 000/001, and load/store funct3!=010, ->ILLEGAL.
//  Latency in cycles, no waits (mem_ready=1):
//    lw 5, sw 4, R/I 4, branch 3, jal 4.
//    Each low mem_ready cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
//  Unused state codes go to FETCH next cycle.
//  rst mid-instruction aborts immediately: strobes drop asynchronously, state=FETCH.
// TESTING
//  1. rst pulse mid-MEMWRITE -> MemWrite drops same cycle; after release state=FETCH, IRWrite only with mem_ready.
//  2. add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXECR(ALUControl=000),ALUWB(RegWrite=1); sub 0x402081B3 -> 001.
//  3. lw 0x0000A183, mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles; RegWrite only in MEMWB, ResultSrc=01.
//  4. beq 0x00208463: zero=1 -> PCWrite=1 in BRANCH, ALUControl=001; zero=0 -> PCWrite=0; bne inverts.
//  5. srai 0x4020D193 and opcode 0x7F -> ILLEGAL, illegal=1, no strobes for 20 cycles until rst.
//  6. jal 0x008000EF -> JAL (PCWrite=1, A=01, B=10) then ALUWB (RegWrite=1); total 4 cycles.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle RV32 core: IR contents and flags come in,
// ALU selects and register/memory/PC strobes go out.
interface multicycle_control_unit_if #(
    parameter int STATE_W = 4
);
    logic [31:0]        instr;
    logic               zero;
    logic               mem_ready;
    logic [2:0]         ALUControl;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic [1:0]         ImmSrc;
    logic               AdrSrc;
    logic               IRWrite;
    logic               PCWrite;
    logic               MemWrite;
    logic               RegWrite;
    logic               illegal;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  instr, zero, mem_ready,
        output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
               IRWrite, PCWrite, MemWrite, RegWrite, illegal, state_o
    );

    modport slave (
        output instr, zero, mem_ready,
        input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
               IRWrite, PCWrite, MemWrite, RegWrite, illegal, state_o
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle RV32 core (lw/sw/R/I/beq/bne/jal). Control fields are
// registered per state; strobes are those flops gated by mem_ready, zero and reset.
module multicycle_control_unit #(
    parameter bit SUPPORT_BNE = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECR    = STATE_W'(6),
        EXECI    = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9),
        JAL      = STATE_W'(10),
        ILLEGAL  = STATE_W'(11)
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic [2:0] alu;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res_src;
        logic       adr_src;
        logic       fetch_wr;  // IRWrite and PCWrite, both qualified by mem_ready
        logic       pcw;
        logic       br;
        logic       bne;
        logic       memw;
        logic       regw;
        logic       illegal;
    } ctl_t;

    function automatic logic [2:0] aludec(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [2:0] a;
        case (f3)
            3'b000:         a = (is_r && f7b5) ? 3'b001 : 3'b000;
            3'b111:         a = 3'b010;
            3'b110:         a = 3'b011;
            3'b100:         a = 3'b100;
            3'b010, 3'b011: a = 3'b101;
            3'b001:         a = 3'b110;
            default:        a = 3'b111;
        endcase
        return a;
    endfunction

    function automatic ctl_t decode_ctl(input state_t s, input logic [2:0] alu_op, input logic bne);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.src_b    = 2'b10;
                c.res_src  = 2'b10;
                c.fetch_wr = 1'b1;
            end
            DECODE: begin
                c.src_a = 2'b01;
                c.src_b = 2'b01;
            end
            MEMADR: begin
                c.src_a = 2'b10;
                c.src_b = 2'b01;
            end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB: begin
                c.res_src = 2'b01;
                c.regw    = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src = 1'b1;
                c.memw    = 1'b1;
            end
            EXECR: begin
                c.src_a = 2'b10;
                c.alu   = alu_op;
            end
            EXECI: begin
                c.src_a = 2'b10;
                c.src_b = 2'b01;
                c.alu   = alu_op;
            end
            ALUWB:    c.regw = 1'b1;
            BRANCH: begin
                c.src_a = 2'b10;
                c.alu   = 3'b001;
                c.br    = 1'b1;
                c.bne   = bne;
            end
            JAL: begin
                c.src_a = 2'b01;
                c.src_b = 2'b10;
                c.pcw   = 1'b1;
            end
            ILLEGAL:  c.illegal = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;

    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       unused_instr;

    assign op           = bus.instr[6:0];
    assign f3           = bus.instr[14:12];
    assign f7b5         = bus.instr[30];
    assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = (f3 == 3'b010) ? MEMADR : ILLEGAL;
                    OP_R:         state_d = (f3 == 3'b101 && f7b5) ? ILLEGAL : EXECR;
                    OP_I:         state_d = (f3 == 3'b101 && f7b5) ? ILLEGAL : EXECI;
                    OP_BR:        state_d = (f3 == 3'b000 || (f3 == 3'b001 && SUPPORT_BNE))
                                            ? BRANCH : ILLEGAL;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = bus.mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            ILLEGAL:  state_d = ILLEGAL;
            default:  state_d = FETCH;
        endcase
        // Fields are decoded for the state being entered so they appear straight from flops.
        ctl_d = decode_ctl(state_d, aludec(f3, f7b5, op == OP_R), f3[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            ctl_q   <= decode_ctl(FETCH, 3'b000, 1'b0);
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    always_comb begin
        bus.ImmSrc = 2'b00;
        case (op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.ALUControl = ctl_q.alu;
    assign bus.ALUSrcA    = ctl_q.src_a;
    assign bus.ALUSrcB    = ctl_q.src_b;
    assign bus.ResultSrc  = ctl_q.res_src;
    assign bus.AdrSrc     = ctl_q.adr_src;
    assign bus.illegal    = ctl_q.illegal;
    assign bus.state_o    = state_q;

    // Reset gating makes the strobes drop the moment rst rises, not at the next edge.
    assign bus.IRWrite  = ~rst & ctl_q.fetch_wr & bus.mem_ready;
    assign bus.PCWrite  = ~rst & ((ctl_q.fetch_wr & bus.mem_ready) | ctl_q.pcw |
                                  (ctl_q.br & (bus.zero ^ ctl_q.bne)));
    assign bus.MemWrite = ~rst & ctl_q.memw;
    assign bus.RegWrite = ~rst & ctl_q.regw;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle scoreboard bench for the multicycle control unit.
module tb_multicycle_control_unit;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_ILLEGAL = 4'd11;

    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRL  = 32'h0020D1B3;
    localparam logic [31:0] I_ADDI = 32'h40008193;
    localparam logic [31:0] I_XORI = 32'h0050C193;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic clk = 1'b0;
    logic rst;

    multicycle_control_unit_if #(.STATE_W(4)) bus ();
    multicycle_control_unit #(.SUPPORT_BNE(1'b1), .STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {state, IRWrite, PCWrite, MemWrite, RegWrite, illegal, ALUControl, A, B, ResultSrc, AdrSrc, ImmSrc}
    function automatic logic [20:0] expv(input logic [3:0] st, input logic [2:0] alu,
                                         input logic irw, input logic pcw, input logic mw,
                                         input logic rw, input logic il, input logic [31:0] ins);
        logic [2:0] a_alu;
        logic [1:0] a, b, rs, imm;
        logic       adr;
        a_alu = 3'b000; a = 2'b00; b = 2'b00; rs = 2'b00; adr = 1'b0;
        case (st)
            S_FETCH:    begin b = 2'b10; rs = 2'b10; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMREAD:  adr = 1'b1;
            S_MEMWB:    rs = 2'b01;
            S_MEMWRITE: adr = 1'b1;
            S_EXECR:    begin a = 2'b10; a_alu = alu; end
            S_EXECI:    begin a = 2'b10; b = 2'b01; a_alu = alu; end
            S_BRANCH:   begin a = 2'b10; a_alu = 3'b001; end
            S_JAL:      begin a = 2'b01; b = 2'b10; end
            default:    ;
        endcase
        case (ins[6:0])
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        return {st, irw, pcw, mw, rw, il, a_alu, a, b, rs, adr, imm};
    endfunction

    function automatic logic [20:0] observed();
        return {bus.state_o, bus.IRWrite, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.illegal,
                bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc, bus.ImmSrc};
    endfunction

    // One clock: drive inputs just after the edge and push what the outputs must be this cycle.
    task automatic cyc(input string tag, input logic [31:0] ins, input logic z, input logic mr,
                       input logic r, input logic [3:0] st, input logic [2:0] alu,
                       input logic irw, input logic pcw, input logic mw, input logic rw,
                       input logic il);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; bus.instr = ins; bus.zero = z; bus.mem_ready = mr;
        e.tag = tag;
        e.v   = expv(st, alu, irw, pcw, mw, rw, il, ins);
        sb.push_back(e);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] ins, input logic [3:0] st_ex,
                           input logic [2:0] alu);
        cyc({tag, "_f"}, ins, 1'b0, 1'b1, 1'b0, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_d"}, ins, 1'b1, 1'b0, 1'b0, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_x"}, ins, 1'b1, 1'b0, 1'b0, st_ex,    alu,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_w"}, ins, 1'b0, 1'b0, 1'b0, S_ALUWB,  3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_br(input string tag, input logic [31:0] ins, input logic z, input logic pcw);
        cyc({tag, "_f"}, ins, 1'b0, 1'b1, 1'b0, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_d"}, ins, 1'b1, 1'b1, 1'b0, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_b"}, ins, z,    1'b1, 1'b0, S_BRANCH, 3'd1, 1'b0, pcw,  1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, 32'(observed()), 32'(e.v));
        end
    end

    initial begin
        rst = 1'b1; bus.instr = I_SW; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // Reset, then an sw interrupted by reset while waiting in MEMWRITE
        cyc("rst_hold", I_SW, 1'b0, 1'b1, 1'b1, S_FETCH,    3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw_f",     I_SW, 1'b0, 1'b1, 1'b0, S_FETCH,    3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("sw_d",     I_SW, 1'b1, 1'b1, 1'b0, S_DECODE,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw_a",     I_SW, 1'b0, 1'b1, 1'b0, S_MEMADR,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw_wait",  I_SW, 1'b0, 1'b0, 1'b0, S_MEMWRITE, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("sw_rst",   I_SW, 1'b0, 1'b0, 1'b1, S_FETCH,    3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rel_nomr", I_SW, 1'b0, 1'b0, 1'b0, S_FETCH,    3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Uninterrupted sw: 4 cycles
        cyc("sw2_f", I_SW, 1'b0, 1'b1, 1'b0, S_FETCH,    3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("sw2_d", I_SW, 1'b0, 1'b1, 1'b0, S_DECODE,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw2_a", I_SW, 1'b0, 1'b1, 1'b0, S_MEMADR,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw2_w", I_SW, 1'b0, 1'b1, 1'b0, S_MEMWRITE, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // ALU ops
        run_alu("add",  I_ADD,  S_EXECR, 3'b000);
        run_alu("sub",  I_SUB,  S_EXECR, 3'b001);
        run_alu("srl",  I_SRL,  S_EXECR, 3'b111);
        run_alu("addi", I_ADDI, S_EXECI, 3'b000);
        run_alu("xori", I_XORI, S_EXECI, 3'b100);

        // lw with one FETCH wait and two MEMREAD waits
        cyc("lw_fw", I_LW, 1'b0, 1'b0, 1'b0, S_FETCH,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw_f",  I_LW, 1'b0, 1'b1, 1'b0, S_FETCH,   3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lw_d",  I_LW, 1'b0, 1'b1, 1'b0, S_DECODE,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw_a",  I_LW, 1'b0, 1'b1, 1'b0, S_MEMADR,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw_r0", I_LW, 1'b0, 1'b0, 1'b0, S_MEMREAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw_r1", I_LW, 1'b0, 1'b0, 1'b0, S_MEMREAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw_r2", I_LW, 1'b0, 1'b1, 1'b0, S_MEMREAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw_wb", I_LW, 1'b0, 1'b1, 1'b0, S_MEMWB,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Branches: taken/not-taken for beq and bne
        run_br("beq_t", I_BEQ, 1'b1, 1'b1);
        run_br("beq_n", I_BEQ, 1'b0, 1'b0);
        run_br("bne_t", I_BNE, 1'b0, 1'b1);
        run_br("bne_n", I_BNE, 1'b1, 1'b0);

        // jal: 4 cycles, PC redirect then link write
        cyc("jal_f", I_JAL, 1'b0, 1'b1, 1'b0, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("jal_d", I_JAL, 1'b0, 1'b1, 1'b0, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jal_j", I_JAL, 1'b0, 1'b1, 1'b0, S_JAL,    3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("jal_w", I_JAL, 1'b0, 1'b1, 1'b0, S_ALUWB,  3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // srai is not supported: absorbing ILLEGAL until reset
        cyc("srai_f", I_SRAI, 1'b0, 1'b1, 1'b0, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("srai_d", I_SRAI, 1'b0, 1'b1, 1'b0, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc("srai_ill", I_SRAI, i[0], 1'b1, 1'b0, S_ILLEGAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("ill_rst", I_BAD, 1'b0, 1'b1, 1'b1, S_FETCH, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Unknown opcode
        cyc("bad_f", I_BAD, 1'b0, 1'b1, 1'b0, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("bad_d", I_BAD, 1'b0, 1'b1, 1'b0, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc("bad_ill", I_BAD, 1'b1, 1'b1, 1'b0, S_ILLEGAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("bad_rst", I_ADD, 1'b0, 1'b1, 1'b1, S_FETCH, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("post_f",  I_ADD, 1'b0, 1'b1, 1'b0, S_FETCH, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
